// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider sequencer: op bit indices, FSM states, width.
package div_ctrl_pkg;

    localparam int DIV_XLEN = 32;

    localparam int DIV_OP_DIV_W  = 0;
    localparam int DIV_OP_DIV_WU = 1;
    localparam int DIV_OP_MOD_W  = 2;
    localparam int DIV_OP_MOD_WU = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } div_state_e;

    function automatic logic op_is_signed(input logic [3:0] op);
        return op[DIV_OP_DIV_W] | op[DIV_OP_MOD_W];
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return op[DIV_OP_DIV_W] | op[DIV_OP_DIV_WU];
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response and divider-IP AXI-stream signals of the divider sequencer.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface div_ctrl_if #(
    parameter int XLEN = div_ctrl_pkg::DIV_XLEN
);
    logic              req_valid;
    logic [3:0]        req_op;
    logic [XLEN-1:0]   req_src1;
    logic [XLEN-1:0]   req_src2;
    logic              req_ready;
    logic              cancel;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_result;
    logic              resp_ready;
    logic              busy;
    logic [XLEN-1:0]   div_dividend;
    logic [XLEN-1:0]   div_divisor;
    logic              s_tvalid;
    logic              s_dividend_tready;
    logic              s_divisor_tready;
    logic              s_dout_tvalid;
    logic [2*XLEN-1:0] s_dout_tdata;
    logic              u_tvalid;
    logic              u_dividend_tready;
    logic              u_divisor_tready;
    logic              u_dout_tvalid;
    logic [2*XLEN-1:0] u_dout_tdata;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, cancel, resp_ready,
        input  s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
        input  u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata,
        output req_ready, resp_valid, resp_result, busy,
        output div_dividend, div_divisor, s_tvalid, u_tvalid
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, cancel, resp_ready,
        output s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
        output u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata,
        input  req_ready, resp_valid, resp_result, busy,
        input  div_dividend, div_divisor, s_tvalid, u_tvalid
    );

endinterface

// File: rtl/div_axis_port.sv
// Operand tvalid, handshake detect and outstanding-result tracking for one divider IP.
module div_axis_port (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_dividend_tready,
    input  logic i_divisor_tready,
    input  logic i_dout_tvalid,
    output logic o_tvalid,
    output logic o_handshake,
    output logic o_result_hit
);

    logic r_tvalid;
    logic r_pending;
    logic w_handshake;

    assign w_handshake  = r_tvalid & i_dividend_tready & i_divisor_tready;
    assign o_tvalid     = r_tvalid;
    assign o_handshake  = w_handshake;
    // Only a result that belongs to an accepted operand pair counts; strays are ignored.
    assign o_result_hit = r_pending & i_dout_tvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tvalid  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (i_start) begin
                r_tvalid <= 1'b1;
            end else if (w_handshake) begin
                r_tvalid <= 1'b0;
            end
            if (w_handshake) begin
                r_pending <= 1'b1;
            end else if (i_dout_tvalid) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer sharing the signed/unsigned AXI-stream divider IPs with the EX stage.
// Optional DIV_ZERO_BYPASS_EN: zero divisors are answered directly without the IP.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic       clk,
    input  logic       reset,
    div_ctrl_if.slave  bus,
    output div_state_e o_dbg_state
);

    div_state_e      r_state;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_src1;
    logic [XLEN-1:0] r_src2;
    logic [XLEN-1:0] r_resp_result;
    logic            r_resp_valid;
    logic            r_cancel_pend;

    logic            w_accept;
    logic            w_bypass;
    logic            w_req_signed;
    logic            w_start_s;
    logic            w_start_u;
    logic            w_sel_signed;
    logic            w_s_tvalid, w_s_hs, w_s_hit;
    logic            w_u_tvalid, w_u_hs, w_u_hit;
    logic            w_hs;
    logic            w_hit;
    logic [2*XLEN-1:0] w_dout;
    logic [XLEN-1:0] w_dout_pick;
    logic [XLEN-1:0] w_bypass_result;

    assign w_accept     = bus.req_valid && (r_state == ST_IDLE) && !bus.cancel && (|bus.req_op);
    assign w_req_signed = op_is_signed(bus.req_op);

`ifdef DIV_ZERO_BYPASS_EN
    assign w_bypass = (bus.req_src2 == '0);
`else
    assign w_bypass = 1'b0;
`endif
    assign w_bypass_result = op_is_div(bus.req_op) ? '1 : bus.req_src1;

    assign w_start_s = w_accept && !w_bypass && w_req_signed;
    assign w_start_u = w_accept && !w_bypass && !w_req_signed;

    div_axis_port u_port_s (
        .clk               (clk),
        .reset             (reset),
        .i_start           (w_start_s),
        .i_dividend_tready (bus.s_dividend_tready),
        .i_divisor_tready  (bus.s_divisor_tready),
        .i_dout_tvalid     (bus.s_dout_tvalid),
        .o_tvalid          (w_s_tvalid),
        .o_handshake       (w_s_hs),
        .o_result_hit      (w_s_hit)
    );

    div_axis_port u_port_u (
        .clk               (clk),
        .reset             (reset),
        .i_start           (w_start_u),
        .i_dividend_tready (bus.u_dividend_tready),
        .i_divisor_tready  (bus.u_divisor_tready),
        .i_dout_tvalid     (bus.u_dout_tvalid),
        .o_tvalid          (w_u_tvalid),
        .o_handshake       (w_u_hs),
        .o_result_hit      (w_u_hit)
    );

    assign w_sel_signed = op_is_signed(r_op);
    assign w_hs         = w_sel_signed ? w_s_hs  : w_u_hs;
    assign w_hit        = w_sel_signed ? w_s_hit : w_u_hit;
    assign w_dout       = w_sel_signed ? bus.s_dout_tdata : bus.u_dout_tdata;
    // IP data is {quotient, remainder}.
    assign w_dout_pick  = op_is_div(r_op) ? w_dout[2*XLEN-1:XLEN] : w_dout[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_resp_result <= '0;
            r_resp_valid  <= 1'b0;
            r_cancel_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op          <= bus.req_op;
                        r_src1        <= bus.req_src1;
                        r_src2        <= bus.req_src2;
                        r_cancel_pend <= 1'b0;
                        if (w_bypass) begin
                            r_resp_result <= w_bypass_result;
                            r_resp_valid  <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    // tvalid may not be withdrawn, so a cancel here is remembered until the IP takes the operands.
                    if (w_hs) begin
                        r_state       <= (bus.cancel || r_cancel_pend) ? ST_DRAIN : ST_WAIT;
                        r_cancel_pend <= 1'b0;
                    end else if (bus.cancel) begin
                        r_cancel_pend <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_hit) begin
                        if (bus.cancel) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_resp_result <= w_dout_pick;
                            r_resp_valid  <= 1'b1;
                            r_state       <= ST_DONE;
                        end
                    end else if (bus.cancel) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_hit) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (bus.cancel || bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (r_state == ST_IDLE);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_result  = r_resp_result;
    assign bus.div_dividend = r_src1;
    assign bus.div_divisor  = r_src2;
    assign bus.s_tvalid     = w_s_tvalid;
    assign bus.u_tvalid     = w_u_tvalid;
    assign o_dbg_state      = r_state;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && bus.req_valid) begin
            assert ($countones(bus.req_op) <= 1);
        end
    end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table, directed cancel/stall sequences, random traffic.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int XL = 32;

    logic       clk = 1'b0;
    logic       reset;
    div_state_e dbg_state;

    div_ctrl_if #(.XLEN(XL)) bus ();

    div_ctrl #(.XLEN(XL)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [XL-1:0] exp_q[$];
    int          ip_lat   = 3;
    int          s_hs_cnt = 0;
    int          u_hs_cnt = 0;
    int          s_tv_cyc = 0;
    int          u_tv_cyc = 0;
    int          resp_seen = 0;
    bit          rand_rdy = 1'b0;

    typedef struct {
        logic [3:0]    op;
        logic [XL-1:0] a;
        logic [XL-1:0] b;
        logic [XL-1:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sdiv_ref(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {q, r};
    endfunction

    function automatic logic [63:0] udiv_ref(input logic [31:0] a, input logic [31:0] b);
        return {a / b, a % b};
    endfunction

    function automatic logic [31:0] exp_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        d = (op[0] | op[2]) ? sdiv_ref(a, b) : udiv_ref(a, b);
        return (op[0] | op[1]) ? d[63:32] : d[31:0];
    endfunction

    // Divider IP models: fixed latency after the operand handshake, one result pulse.
    logic [63:0] s_pend_data;
    logic [63:0] u_pend_data;
    int          s_cnt = 0;
    int          u_cnt = 0;

    always @(negedge clk) begin
        bus.s_dout_tvalid = 1'b0;
        bus.u_dout_tvalid = 1'b0;
        if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) begin
                bus.s_dout_tvalid = 1'b1;
                bus.s_dout_tdata  = s_pend_data;
            end
        end
        if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
                bus.u_dout_tvalid = 1'b1;
                bus.u_dout_tdata  = u_pend_data;
            end
        end
        if (reset === 1'b0) begin
            if (bus.s_tvalid) s_tv_cyc++;
            if (bus.u_tvalid) u_tv_cyc++;
            if (bus.s_tvalid && bus.s_dividend_tready && bus.s_divisor_tready) begin
                s_hs_cnt++;
                s_pend_data = sdiv_ref(bus.div_dividend, bus.div_divisor);
                s_cnt = ip_lat;
            end
            if (bus.u_tvalid && bus.u_dividend_tready && bus.u_divisor_tready) begin
                u_hs_cnt++;
                u_pend_data = udiv_ref(bus.div_dividend, bus.div_divisor);
                u_cnt = ip_lat;
            end
        end
    end

    // Scoreboard: every consumed response must match the oldest expected value.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.resp_valid) resp_seen++;
        if (reset === 1'b0 && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp_unexpected: got 0x%0h expected no response", bus.resp_result);
            end else begin
                check("resp_result", bus.resp_result, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            bus.s_dividend_tready = ($urandom_range(0, 3) != 0);
            bus.s_divisor_tready  = ($urandom_range(0, 3) != 0);
            bus.u_dividend_tready = ($urandom_range(0, 3) != 0);
            bus.u_divisor_tready  = ($urandom_range(0, 3) != 0);
            bus.resp_ready        = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic set_s_ready(input logic v);
        bus.s_dividend_tready = v;
        bus.s_divisor_tready  = v;
    endtask

    task automatic send_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [31:0] exp);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        while (!bus.req_ready && t < 200) begin
            tick();
            t++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_timeout: req_ready=0 expected 1");
        end else if (push) begin
            exp_q.push_back(exp);
        end
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0000;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((bus.busy || exp_q.size() != 0) && t < 500) begin
            tick();
            t++;
        end
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_state(input string name, input div_state_e st, input int budget);
        int t = 0;
        while (dbg_state != st && t < budget) begin
            tick();
            t++;
        end
        check(name, 32'(dbg_state), 32'(st));
    endtask

    int s_tv0, u_tv0, hs0, rs0;
    logic [31:0] held;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b0001, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD};
        vecs[1]  = '{4'b0100, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF};
        vecs[2]  = '{4'b0001, 32'd100,       32'd7,       32'h0000_000E};
        vecs[3]  = '{4'b0100, 32'd100,       32'd7,       32'h0000_0002};
        vecs[4]  = '{4'b0001, 32'hFFFF_FF9C, 32'd7,       32'hFFFF_FFF2};
        vecs[5]  = '{4'b0100, 32'hFFFF_FF9C, 32'd7,       32'hFFFF_FFFE};
        vecs[6]  = '{4'b0001, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[7]  = '{4'b0100, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001};
        vecs[8]  = '{4'b0010, 32'hFFFF_FFF9, 32'd2,       32'h7FFF_FFFC};
        vecs[9]  = '{4'b1000, 32'hFFFF_FFF9, 32'd2,       32'h0000_0001};
        vecs[10] = '{4'b0010, 32'd9,         32'd4,       32'h0000_0002};
        vecs[11] = '{4'b1000, 32'd9,         32'd4,       32'h0000_0001};
        vecs[12] = '{4'b0010, 32'hFFFF_FFFF, 32'h10,      32'h0FFF_FFFF};
        vecs[13] = '{4'b1000, 32'hFFFF_FFFF, 32'h10,      32'h0000_000F};

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0000;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.cancel    = 1'b0;
        bus.resp_ready = 1'b1;
        set_s_ready(1'b1);
        bus.u_dividend_tready = 1'b1;
        bus.u_divisor_tready  = 1'b1;
        repeat (3) tick();

        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_result", bus.resp_result, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_s_tvalid", 32'(bus.s_tvalid), 32'd0);
        check("rst_u_tvalid", 32'(bus.u_tvalid), 32'd0);
        check("rst_dividend", bus.div_dividend, 32'd0);
        check("rst_divisor", bus.div_divisor, 32'd0);
        reset = 1'b0;
        tick();

        // Signed vectors must never touch the unsigned IP, and vice versa.
        u_tv0 = u_tv_cyc;
        for (int i = 0; i < 8; i++) begin
            send_req(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
            wait_idle("vec_s");
        end
        check("u_tvalid_unused", 32'(u_tv_cyc), 32'(u_tv0));
        s_tv0 = s_tv_cyc;
        for (int i = 8; i < 14; i++) begin
            send_req(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
            wait_idle("vec_u");
        end
        check("s_tvalid_unused", 32'(s_tv_cyc), 32'(s_tv0));

        // Signed IP not ready for 3 cycles: tvalid and operands must hold.
        set_s_ready(1'b0);
        hs0 = s_hs_cnt;
        send_req(4'b0001, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
        for (int i = 0; i < 3; i++) begin
            check("stall_tvalid", 32'(bus.s_tvalid), 32'd1);
            check("stall_dividend", bus.div_dividend, 32'hFFFF_FFF9);
            check("stall_divisor", bus.div_divisor, 32'd2);
            tick();
        end
        check("stall_tvalid_c4", 32'(bus.s_tvalid), 32'd1);
        set_s_ready(1'b1);
        tick();
        check("stall_tvalid_drop", 32'(bus.s_tvalid), 32'd0);
        check("stall_one_hs", 32'(s_hs_cnt), 32'(hs0 + 1));
        wait_idle("stall");

        // Cancel while in WAIT: result drained, next op gets its own result.
        ip_lat = 6;
        rs0 = resp_seen;
        send_req(4'b0001, 32'd100, 32'd7, 1'b0, 32'd0);
        wait_state("cw_wait", ST_WAIT, 20);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cw_drain", 32'(dbg_state), 32'(ST_DRAIN));
        wait_state("cw_idle", ST_IDLE, 30);
        check("cw_no_resp", 32'(resp_seen), 32'(rs0));
        send_req(4'b0010, 32'd9, 32'd4, 1'b1, 32'h2);
        wait_idle("cw_next");

        // Cancel while in SEND with IP stalled: tvalid held until the handshake, then drain.
        set_s_ready(1'b0);
        hs0 = s_hs_cnt;
        rs0 = resp_seen;
        send_req(4'b0001, 32'd100, 32'd7, 1'b0, 32'd0);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cs_tvalid_held", 32'(bus.s_tvalid), 32'd1);
        tick();
        set_s_ready(1'b1);
        tick();
        check("cs_one_hs", 32'(s_hs_cnt), 32'(hs0 + 1));
        check("cs_drain", 32'(dbg_state), 32'(ST_DRAIN));
        wait_state("cs_idle", ST_IDLE, 30);
        check("cs_no_resp", 32'(resp_seen), 32'(rs0));
        send_req(4'b0100, 32'd100, 32'd7, 1'b1, 32'h2);
        wait_idle("cs_next");

        // Cancel together with a request in IDLE: not accepted.
        bus.req_valid = 1'b1;
        bus.req_op    = 4'b0001;
        bus.req_src1  = 32'd50;
        bus.req_src2  = 32'd5;
        bus.cancel    = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0000;
        bus.cancel    = 1'b0;
        check("ci_busy", 32'(bus.busy), 32'd0);
        check("ci_s_tvalid", 32'(bus.s_tvalid), 32'd0);

        // Cancel in DONE: response dropped without a handshake.
        ip_lat = 2;
        bus.resp_ready = 1'b0;
        send_req(4'b0010, 32'd9, 32'd4, 1'b0, 32'd0);
        wait_state("cd_done", ST_DONE, 30);
        check("cd_resp_valid", 32'(bus.resp_valid), 32'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cd_resp_dropped", 32'(bus.resp_valid), 32'd0);
        check("cd_req_ready", 32'(bus.req_ready), 32'd1);

        // Response back-pressure for 5 cycles.
        send_req(4'b0001, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
        wait_state("bp_done", ST_DONE, 30);
        held = bus.resp_result;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("bp_resp_stable", bus.resp_result, 32'hFFFF_FFFD);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        check("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
        check("bp_resp_valid_after", 32'(bus.resp_valid), 32'd0);
        check("bp_held", held, 32'hFFFF_FFFD);
        wait_idle("bp");

`ifdef DIV_ZERO_BYPASS_EN
        s_tv0 = s_tv_cyc;
        u_tv0 = u_tv_cyc;
        send_req(4'b0001, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF);
        check("bz_div_valid", 32'(bus.resp_valid), 32'd1);
        check("bz_div_result", bus.resp_result, 32'hFFFF_FFFF);
        wait_idle("bz_div");
        send_req(4'b1000, 32'd5, 32'd0, 1'b1, 32'h5);
        check("bz_mod_valid", 32'(bus.resp_valid), 32'd1);
        check("bz_mod_result", bus.resp_result, 32'h5);
        wait_idle("bz_mod");
        check("bz_no_s_tvalid", 32'(s_tv_cyc), 32'(s_tv0));
        check("bz_no_u_tvalid", 32'(u_tv_cyc), 32'(u_tv0));
`endif

        // Random traffic with random IP readiness, latency and response back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'(1 << $urandom_range(0, 3));
            a  = $urandom;
            b  = 32'($urandom_range(1, 1000));
            if ((op[0] | op[2]) && ($urandom_range(0, 1) == 1)) b = -b;
            ip_lat = int'($urandom_range(1, 5));
            send_req(op, a, b, 1'b1, exp_of(op, a, b));
            wait_idle("rand");
        end
        rand_rdy = 1'b0;
        bus.resp_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
